// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing defaults, coordinate width and window helpers
package vga_timing_pkg;

  localparam int COORD_W = 11;

  localparam int H_VIS_D  = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_VIS_D  = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;

  function automatic int total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int vis, input int fp);
    return vis + fp;
  endfunction

  function automatic int sync_end(input int vis, input int fp, input int sync);
    return vis + fp + sync - 1;
  endfunction

  function automatic logic in_win(input logic [COORD_W-1:0] c,
                                  input logic [COORD_W-1:0] lo,
                                  input logic [COORD_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/cnt_mod.sv
// rtl/cnt_mod.sv - modulo counter with enable, synchronous load and wrap strobe
module cnt_mod #(
  parameter int           W    = 11,
  parameter logic [W-1:0] LAST = '1,
  parameter logic [W-1:0] LOAD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  logic [W-1:0] cnt;

  // nxt is the value cnt takes on this edge; the top registers its outputs from it
  always_comb begin
    wrap = en && (cnt == LAST);
    nxt  = cnt;
    if (en) begin
      nxt = (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LOAD;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/vga_sinc_gen.sv
// rtl/vga_sinc_gen.sv - VGA sync, position and line/frame strobe generator
module vga_sinc_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = H_VIS_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_VIS    = V_VIS_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic               h_sinc,
  output logic               v_sinc,
  output logic               video_on,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0] H_SS = COORD_W'(sync_start(H_VIS, H_FP));
  localparam logic [COORD_W-1:0] H_SE = COORD_W'(sync_end(H_VIS, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] V_SS = COORD_W'(sync_start(V_VIS, V_FP));
  localparam logic [COORD_W-1:0] V_SE = COORD_W'(sync_end(V_VIS, V_FP, V_SYNC));

  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;
  logic               h_wrap;
  logic               v_wrap;

  // Counters park on the last position so the first pixel tick lands on (0,0)
  cnt_mod #(
    .W    (COORD_W),
    .LAST (H_LAST),
    .LOAD (H_LAST)
  ) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .nxt  (h_nxt),
    .wrap (h_wrap)
  );

  cnt_mod #(
    .W    (COORD_W),
    .LAST (V_LAST),
    .LOAD (V_LAST)
  ) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .nxt  (v_nxt),
    .wrap (v_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x       <= '0;
      pos_y       <= '0;
      video_on    <= 1'b0;
      h_sinc      <= ~SYNC_POL;
      v_sinc      <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // wraps are gated by pix_en, so the strobes drop on the following clk
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (pix_en) begin
        pos_x    <= h_nxt;
        pos_y    <= v_nxt;
        video_on <= (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
        h_sinc   <= in_win(h_nxt, H_SS, H_SE) ? SYNC_POL : ~SYNC_POL;
        v_sinc   <= in_win(v_nxt, V_SS, V_SE) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: doc/vga_sinc_gen.md
# vga_sinc_gen

Sync and position generator for the 640x480@60 Hz VGA path. It produces the horizontal and vertical sync pulses, an active-video flag, the current pixel coordinates, and line/frame start strobes. It sits directly upstream of the digit renderer (`PosPant`). The renderer draws the six clock digits from `pos_x`/`pos_y`/`video_on` instead of reconstructing position from the sync lines.

## Interface

Parameters:
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active level of `h_sinc`/`v_sinc` (0 = active-low)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel tick; counters advance only on `clk` edges where `pix_en`=1
- `h_sinc`  out  1  horizontal sync
- `v_sinc`  out  1  vertical sync
- `video_on`  out  1  1 when the current position is visible
- `pos_x`  out  11  current horizontal count, 0..H_TOTAL-1
- `pos_y`  out  11  current vertical count, 0..V_TOTAL-1
- `line_start`  out  1  one-`clk` strobe when `pos_x` becomes 0
- `frame_start`  out  1  one-`clk` strobe when (`pos_x`,`pos_y`) becomes (0,0)

## Operation

- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (default 525). Both totals must be ≤ 2047; counters are fixed at 11 bits.
- Horizontal layout, in `h_cnt` order starting at 0:
  - visible [0, H_VIS-1]
  - front porch [H_VIS, H_VIS+H_FP-1]
  - sync [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], which is 656..751 by default
  - back porch up to H_TOTAL-1
- Vertical layout uses the same order; sync lines are 490..491 by default.
- On each `pix_en` edge:
  - `h_cnt` increments and wraps from H_TOTAL-1 to 0.
  - `v_cnt` increments only on that same h-wrap edge, and wraps from V_TOTAL-1 to 0.
- Outputs:
  - `pos_x` = `h_cnt` and `pos_y` = `v_cnt`, raw values in blanking too.
  - `video_on` = (`h_cnt` < H_VIS) && (`v_cnt` < V_VIS).
  - `h_sinc`/`v_sinc` = SYNC_POL inside the sync window, ~SYNC_POL outside it.
- All outputs are flops, updated on the same edge as the counters and computed from the counters' next values. Position, sync and `video_on` are therefore always mutually consistent and glitch-free.
- `line_start`/`frame_start` assert in the `clk` cycle immediately after the `pix_en` edge that entered `h_cnt`=0 (and `v_cnt`=0 for `frame_start`). They clear on the next `clk`, regardless of `pix_en`.
- Reset:
  - Internal counters load (H_TOTAL-1, V_TOTAL-1).
  - Outputs go to `pos_x`=`pos_y`=0, `video_on`=0, syncs inactive (~SYNC_POL), strobes 0.
  - The first `pix_en` edge after reset enters (0,0) with `video_on`=1, `line_start`=1 and `frame_start`=1.
- `rst` during any state, mid-line or mid-sync, takes effect on that edge and overrides `pix_en`.

## Timing

- Latency is zero from counter state to outputs; both change on the same `pix_en` edge.
- With `pix_en` held at 1 and a 25 MHz `clk`:
  - line = 800 clk
  - frame = 420000 clk
  - `h_sinc` active for 96 clk
  - `v_sinc` active for 1600 clk
- While `pix_en`=0, all outputs except the strobes hold their values.
- The `video_on` falling edge occurs when `pos_x` goes 639→640; there is no 1-pixel skew relative to `pos_x`.

## Structure

- Package `vga_timing_pkg` holds:
  - the 640x480@60 default constants,
  - derived H_TOTAL/V_TOTAL and sync-window start/end,
  - the 11-bit coordinate width.
- Sub-module `cnt_mod`: a generic modulo-N counter with enable, synchronous reset-to-load-value and a wrap (carry) output. It is instantiated twice, with the horizontal carry ANDed into the vertical enable.
- Estimated 150–250 lines of RTL.

## Test plan

- Reset, then `pix_en`=1 continuous → first enabled edge gives `pos_x`=0, `pos_y`=0, `video_on`=1, `line_start`=`frame_start`=1 for exactly 1 clk.
- One full line → `h_sinc`=0 exactly while `pos_x`∈[656,751] (96 edges); `video_on` drops at `pos_x`=640; next `line_start` arrives 800 clk after the previous one.
- One full frame → `v_sinc`=0 exactly for `pos_y`∈{490,491} (1600 edges); `frame_start` period = 420000 clk; `pos_y` increments only on 799→0 edges.
- `pix_en` toggling 1,0,1,0 → outputs hold during `pix_en`=0; strobes stay 1 clk wide; frame period = 840000 clk.
- `rst` asserted at (300,200) inside visible area for 3 clk → next clk outputs idle (0,0,`video_on`=0, syncs inactive); after release, the first `pix_en` gives (0,0) plus `frame_start`.
- Wrap at (799,524) → next edge gives (0,0), `frame_start`=1, `v_sinc` inactive; with SYNC_POL=1, the sync windows are inverted (high during 656..751 / 490..491).
